// File: rtl/jellyvl_synctimer_adjuster.sv
// jellyvl_synctimer_adjuster: turns a signed time error into evenly spread +/-1 tick adjust requests or a one-shot time jump; define JELLYVL_SYNCTIMER_ADJUSTER_STATUS_EN to enable the stat_* counters
module jellyvl_synctimer_adjuster #(
    parameter int TIMER_WIDTH  = 64,
    parameter int ERROR_WIDTH  = 32,
    parameter int PERIOD_WIDTH = 32,
    parameter int LIMIT        = 1000,
    parameter int SET_OFFSET   = 1
) (
    input  logic                    rst,
    input  logic                    clk,
    input  logic [TIMER_WIDTH-1:0]  current_time,
    input  logic [ERROR_WIDTH-1:0]  in_error,
    input  logic [PERIOD_WIDTH-1:0] in_period,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    cancel,
    output logic [TIMER_WIDTH-1:0]  set_time,
    output logic                    set_valid,
    output logic                    adjust_sign,
    output logic                    adjust_valid,
    input  logic                    adjust_ready,
    output logic                    busy,
    output logic [31:0]             stat_jumps,
    output logic [31:0]             stat_adjusts
);
    localparam int CW = (ERROR_WIDTH > PERIOD_WIDTH) ? ERROR_WIDTH : PERIOD_WIDTH;

    typedef enum logic [1:0] {IDLE, SPREAD, DRAIN} state_t;

    state_t                  state, state_next;
    logic [ERROR_WIDTH-1:0]  abs_in, abs_r, owed, owed_next;
    logic [PERIOD_WIDTH-1:0] period_r, elapsed;
    logic [PERIOD_WIDTH:0]   acc, acc_sum;
    logic                    accept, jump, start, credit, hs;

    assign in_ready     = state == IDLE;
    assign busy         = state != IDLE;
    assign adjust_valid = owed != '0;

    // request classification and Bresenham credit / owed bookkeeping
    always_comb begin
        abs_in    = in_error[ERROR_WIDTH-1] ? -in_error : in_error;
        accept    = in_valid && in_ready;
        jump      = accept && abs_in != '0 && (CW'(abs_in) > CW'(LIMIT) || CW'(abs_in) > CW'(in_period) || in_period == '0);
        start     = accept && abs_in != '0 && !jump;
        hs        = adjust_valid && adjust_ready;
        acc_sum   = acc + (PERIOD_WIDTH+1)'(abs_r);
        credit    = state == SPREAD && acc_sum >= {1'b0, period_r};
        owed_next = owed + ERROR_WIDTH'(credit) - ERROR_WIDTH'(hs);
    end

    // next state: cancel wins, spread lasts exactly period cycles, drain until nothing owed
    always_comb begin
        state_next = state;
        if (cancel)
            state_next = IDLE;
        else if (state == IDLE && start)
            state_next = SPREAD;
        else if (state == SPREAD && elapsed == period_r - PERIOD_WIDTH'(1))
            state_next = DRAIN;
        else if (state == DRAIN && owed_next == '0)
            state_next = IDLE;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // jump strobe, latched request and spreading counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_time    <= '0;
            set_valid   <= 1'b0;
            adjust_sign <= 1'b0;
            abs_r       <= '0;
            period_r    <= '0;
            acc         <= '0;
            elapsed     <= '0;
            owed        <= '0;
        end else begin
            set_valid <= jump;
            if (jump)
                set_time <= current_time + TIMER_WIDTH'($signed(in_error)) + TIMER_WIDTH'(SET_OFFSET);
            if (start) begin
                adjust_sign <= in_error[ERROR_WIDTH-1];
                abs_r       <= abs_in;
                period_r    <= in_period;
            end
            if (cancel) begin
                acc     <= '0;
                elapsed <= '0;
                owed    <= '0;
            end else begin
                if (start) begin
                    acc     <= '0;
                    elapsed <= '0;
                end else if (state == SPREAD) begin
                    acc     <= credit ? acc_sum - {1'b0, period_r} : acc_sum;
                    elapsed <= elapsed + PERIOD_WIDTH'(1);
                end
                owed <= owed_next;
            end
        end
    end

`ifdef JELLYVL_SYNCTIMER_ADJUSTER_STATUS_EN
    // free-running jump and handshake counters, cleared by reset only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_jumps   <= '0;
            stat_adjusts <= '0;
        end else begin
            stat_jumps   <= stat_jumps + 32'(set_valid);
            stat_adjusts <= stat_adjusts + 32'(hs);
        end
    end
`else
    assign stat_jumps   = '0;
    assign stat_adjusts = '0;
`endif

endmodule
